// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer
// Selects the frame presented to the LED shift register. Mode 0 builds a frame
// from the colour switches and is sent manually. Modes 1..NUM_MODES-1 stream
// frames from extData continuously. Mode changes are deferred to a frame
// boundary (frameDone) so that a frame is never torn.
// Optional build macro BLANK_ON_SWITCH_EN: on a mode switch, one all-zero frame
// is inserted before the new mode takes effect.
module led_mode_sequencer #(
    parameter  int NUM_LEDS  = 4,
    parameter  int NUM_MODES = 4,
    localparam int MODE_W    = $clog2(NUM_MODES),
    localparam int FRAME_W   = NUM_LEDS * 24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               changeMode,
    input  logic [MODE_W-1:0]                  modeSet,
    input  logic                               send,
    input  logic [3:0]                         Green,
    input  logic [3:0]                         Red,
    input  logic [3:0]                         Blue,
    input  logic [(NUM_MODES-1)*FRAME_W-1:0]   extData,
    input  logic                               frameDone,
    output logic                               go,
    output logic [FRAME_W-1:0]                 regVal,
    output logic [MODE_W-1:0]                  mode,
    output logic                               busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
`ifdef BLANK_ON_SWITCH_EN
        BLANK   = 2'd2,
`endif
        PENDING = 2'd1
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [MODE_W-1:0]   pendMode;
    logic [MODE_W-1:0]   pendNext;
    logic [MODE_W-1:0]   modeNext;
    logic                sendReq;
    logic                sendReqNext;
    logic                changePrev;
    logic                sendPrev;
    logic                changeEdge;
    logic                sendEdge;
    logic                modeValid;
    logic                validEdge;
    logic                loadMode;
    logic [FRAME_W-1:0]  frameNext;

    // A held button level produces a single event on its rising edge.
    assign changeEdge = changeMode & ~changePrev;
    assign sendEdge   = send & ~sendPrev;

    // Requests for modes that do not exist are dropped.
    assign modeValid  = ({{(32-MODE_W){1'b0}}, modeSet} < NUM_MODES);
    assign validEdge  = changeEdge & modeValid;

    // The newest valid request always wins, even in the cycle it commits.
    assign pendNext   = validEdge ? modeSet : pendMode;
    assign modeNext   = loadMode ? pendNext : mode;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; loadMode marks the cycle the pending mode is applied.
    always_comb begin
        stateNext = state;
        loadMode  = 1'b0;
        case (state)
            RUN: begin
                if (validEdge) begin
                    if (frameDone) begin
                        // Request lands on a frame boundary: commit immediately.
`ifdef BLANK_ON_SWITCH_EN
                        stateNext = BLANK;
`else
                        loadMode  = 1'b1;
`endif
                    end else begin
                        stateNext = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frameDone) begin
`ifdef BLANK_ON_SWITCH_EN
                    stateNext = BLANK;
`else
                    stateNext = RUN;
                    loadMode  = 1'b1;
`endif
                end
            end
`ifdef BLANK_ON_SWITCH_EN
            BLANK: begin
                if (frameDone) begin
                    stateNext = RUN;
                    loadMode  = 1'b1;
                end
            end
`endif
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // Manual-send request: a commit into mode 0 starts idle, a fresh send edge
    // outranks the frameDone that would otherwise clear it.
    always_comb begin
        sendReqNext = sendReq;
        if (loadMode && (pendNext == '0)) begin
            sendReqNext = 1'b0;
        end else if (sendEdge && (mode == '0) && (state == RUN)) begin
            sendReqNext = 1'b1;
        end else if (frameDone) begin
            sendReqNext = 1'b0;
        end
    end

    // Control registers: applied mode, pending mode, send request, edge history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode       <= '0;
            pendMode   <= '0;
            sendReq    <= 1'b0;
            changePrev <= 1'b0;
            sendPrev   <= 1'b0;
        end else begin
            mode       <= modeNext;
            pendMode   <= pendNext;
            sendReq    <= sendReqNext;
            changePrev <= changeMode;
            sendPrev   <= send;
        end
    end

    // Output decode: streaming modes and switch-over states keep the shifter running.
    always_comb begin
        busy = (state != RUN);
        go   = 1'b1;
        if ((state == RUN) && (mode == '0)) begin
            go = sendReq;
        end
    end

    // Frame selection for the current mode; LED0 occupies the MSBs.
    always_comb begin
        frameNext = {NUM_LEDS{Green, 4'h0, Red, 4'h0, Blue, 4'h0}};
        for (int m = 1; m < NUM_MODES; m++) begin
            if (mode == MODE_W'(m)) begin
                frameNext = extData[(m-1)*FRAME_W +: FRAME_W];
            end
        end
`ifdef BLANK_ON_SWITCH_EN
        if (state == BLANK) begin
            frameNext = '0;
        end
`endif
    end

    // Frame load register, refreshed every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regVal <= '0;
        end else begin
            regVal <= frameNext;
        end
    end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Testbench for led_mode_sequencer (NUM_LEDS=4, NUM_MODES=4) plus a
// NUM_MODES=3 instance used for out-of-range mode requests.
module tb_led_mode_sequencer;

    localparam int NL = 4;
    localparam int NM = 4;
    localparam int FW = NL * 24;

    logic            clk;
    logic            reset;
    logic            changeMode;
    logic [1:0]      modeSet;
    logic            send;
    logic [3:0]      Green;
    logic [3:0]      Red;
    logic [3:0]      Blue;
    logic [3*FW-1:0] extData;
    logic            frameDone;
    logic            go;
    logic [FW-1:0]   regVal;
    logic [1:0]      mode;
    logic            busy;

    logic            changeMode3;
    logic [1:0]      modeSet3;
    logic            frameDone3;
    logic [47:0]     extData3;
    logic            go3;
    logic [23:0]     regVal3;
    logic [1:0]      mode3;
    logic            busy3;

    int checks;
    int failures;

    // Reference model state (abstract: pending/blanking flags, integer modes)
    bit            mPrevCh;
    bit            mPrevSend;
    bit            mPendFlag;
    bit            mBlank;
    bit            mSendReq;
    int            mMode;
    int            mPend;
    logic [FW-1:0] expReg;

    led_mode_sequencer #(.NUM_LEDS(NL), .NUM_MODES(NM)) dut (
        .clk(clk), .reset(reset), .changeMode(changeMode), .modeSet(modeSet),
        .send(send), .Green(Green), .Red(Red), .Blue(Blue), .extData(extData),
        .frameDone(frameDone), .go(go), .regVal(regVal), .mode(mode), .busy(busy)
    );

    led_mode_sequencer #(.NUM_LEDS(1), .NUM_MODES(3)) dut3 (
        .clk(clk), .reset(reset), .changeMode(changeMode3), .modeSet(modeSet3),
        .send(1'b0), .Green(Green), .Red(Red), .Blue(Blue), .extData(extData3),
        .frameDone(frameDone3), .go(go3), .regVal(regVal3), .mode(mode3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] frameOf(int m);
        if (m == 0) return {NL{Green, 4'h0, Red, 4'h0, Blue, 4'h0}};
        return extData[(m-1)*FW +: FW];
    endfunction

    function automatic bit expBusy();
        return mPendFlag || mBlank;
    endfunction

    function automatic bit expGo();
        if (!mPendFlag && !mBlank && mMode == 0) return mSendReq;
        return 1'b1;
    endfunction

    // Apply the behavioural rules for one clock edge using the current inputs.
    task automatic modelStep();
        bit chE, sE, validE, wasRun, loaded;
        int newPend, oldMode;
        if (!reset) begin
            mMode = 0; mPend = 0; mPendFlag = 0; mBlank = 0; mSendReq = 0;
            mPrevCh = 0; mPrevSend = 0; expReg = '0;
            return;
        end
        expReg  = mBlank ? '0 : frameOf(mMode);
        chE     = changeMode && !mPrevCh;
        sE      = send && !mPrevSend;
        validE  = chE && (int'(modeSet) < NM);
        newPend = validE ? int'(modeSet) : mPend;
        wasRun  = !mPendFlag && !mBlank;
        oldMode = mMode;
        loaded  = 0;
        if (mBlank) begin
            if (frameDone) begin mBlank = 0; mMode = newPend; loaded = 1; end
        end else if (mPendFlag || validE) begin
            if (frameDone) begin
                mPendFlag = 0;
`ifdef BLANK_ON_SWITCH_EN
                mBlank = 1;
`else
                mMode = newPend; loaded = 1;
`endif
            end else begin
                mPendFlag = 1;
            end
        end
        if (loaded && newPend == 0) mSendReq = 0;
        else if (sE && wasRun && oldMode == 0) mSendReq = 1;
        else if (frameDone) mSendReq = 0;
        mPend     = newPend;
        mPrevCh   = changeMode;
        mPrevSend = send;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; changeMode = 1'b1; modeSet = 2'd2; send = 1'b1; frameDone = 1'b1;
        changeMode3 = 1'b1; modeSet3 = 2'd1; frameDone3 = 1'b1;
        tick(); tick();
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (go !== 1'b0) begin failures++; $display("FAIL reset_go got=%0b exp=0", go); end
        checks++; if (regVal !== '0) begin failures++; $display("FAIL reset_regVal got=%0h exp=0", regVal); end
        checks++; if (mode3 !== 2'd0 || busy3 !== 1'b0) begin failures++; $display("FAIL reset_dut3 got mode=%0d busy=%0b exp 0/0", mode3, busy3); end
        reset = 1'b1; changeMode = 1'b0; send = 1'b0; frameDone = 1'b0;
        changeMode3 = 1'b0; frameDone3 = 1'b0;
        tick();
        checks++; if (regVal !== expReg) begin failures++; $display("FAIL release_regVal got=%0h exp=%0h", regVal, expReg); end
    endtask

    task automatic test_mode0_frame();
        logic [FW-1:0] want;
        want  = {NL{24'hA05030}};
        Green = 4'hA; Red = 4'h5; Blue = 4'h3;
        tick();
        checks++; if (regVal !== want) begin failures++; $display("FAIL mode0_regVal got=%0h exp=%0h", regVal, want); end
        checks++; if (go !== 1'b0) begin failures++; $display("FAIL mode0_go got=%0b exp=0", go); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL mode0_mode got=%0d exp=0", mode); end
    endtask

    task automatic test_send();
        send = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frameDone = (i == 5);
            tick();
            checks++; if (go !== expGo()) begin failures++; $display("FAIL send_go[%0d] got=%0b exp=%0b", i, go, expGo()); end
            if (i == 0) begin
                checks++; if (go !== 1'b1) begin failures++; $display("FAIL send_go_start got=%0b exp=1", go); end
            end
        end
        send = 1'b0; frameDone = 1'b0;
        tick();
        checks++; if (go !== 1'b0) begin failures++; $display("FAIL send_go_after got=%0b exp=0", go); end
        frameDone = 1'b1; tick(); frameDone = 1'b0; tick();
        checks++; if (go !== 1'b0) begin failures++; $display("FAIL send_no_second got=%0b exp=0", go); end
    endtask

    task automatic test_mode_switch();
        for (int i = 0; i < 9; i++) extData[i*32 +: 32] = $urandom;
        modeSet = 2'd2; changeMode = 1'b1;
        tick();
        changeMode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++; if (busy !== 1'b1 || go !== 1'b1) begin failures++; $display("FAIL switch_wait[%0d] got busy=%0b go=%0b exp 1/1", i, busy, go); end
            if (i < 19) tick();
        end
        frameDone = 1'b1; tick(); frameDone = 1'b0;
        checks++; if (mode !== 2'd2 || busy !== 1'b0) begin failures++; $display("FAIL switch_commit got mode=%0d busy=%0b exp 2/0", mode, busy); end
        tick();
        checks++; if (regVal !== extData[2*FW-1:FW]) begin failures++; $display("FAIL switch_regVal got=%0h exp=%0h", regVal, extData[2*FW-1:FW]); end
        checks++; if (go !== 1'b1) begin failures++; $display("FAIL switch_go got=%0b exp=1", go); end
    endtask

    task automatic test_overwrite();
        modeSet = 2'd3; changeMode = 1'b1; tick();
        changeMode = 1'b0; tick(); tick();
        modeSet = 2'd1; changeMode = 1'b1; tick();
        changeMode = 1'b0; tick();
        frameDone = 1'b1; tick(); frameDone = 1'b0;
`ifdef BLANK_ON_SWITCH_EN
        checks++; if (regVal !== frameOf(2)) begin failures++; $display("FAIL blank_prev_regVal got=%0h exp=%0h", regVal, frameOf(2)); end
        tick();
        checks++; if (regVal !== '0) begin failures++; $display("FAIL blank_zero got=%0h exp=0", regVal); end
        frameDone = 1'b1; tick(); frameDone = 1'b0;
`endif
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL overwrite_mode got=%0d exp=1", mode); end
        tick();
        checks++; if (regVal !== extData[FW-1:0]) begin failures++; $display("FAIL overwrite_regVal got=%0h exp=%0h", regVal, extData[FW-1:0]); end
    endtask

    task automatic test_invalid_mode3();
        extData3 = {16'($urandom), $urandom};
        modeSet3 = 2'd3; changeMode3 = 1'b1; tick();
        changeMode3 = 1'b0;
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL invalid_busy got=%0b exp=0", busy3); end
        frameDone3 = 1'b1; tick(); frameDone3 = 1'b0;
        checks++; if (mode3 !== 2'd0) begin failures++; $display("FAIL invalid_mode got=%0d exp=0", mode3); end
        modeSet3 = 2'd2; changeMode3 = 1'b1; tick();
        changeMode3 = 1'b0;
        checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL valid3_busy got=%0b exp=1", busy3); end
        frameDone3 = 1'b1; tick();
`ifdef BLANK_ON_SWITCH_EN
        tick();
`endif
        frameDone3 = 1'b0;
        checks++; if (mode3 !== 2'd2) begin failures++; $display("FAIL valid3_mode got=%0d exp=2", mode3); end
        tick();
        checks++; if (regVal3 !== extData3[47:24]) begin failures++; $display("FAIL valid3_regVal got=%0h exp=%0h", regVal3, extData3[47:24]); end
    endtask

    task automatic test_back_to_back();
        modeSet = 2'd0; changeMode = 1'b1; frameDone = 1'b1; tick();
        changeMode = 1'b0; frameDone = 1'b0;
        checks++; if (mode !== 2'(mMode) || busy !== expBusy()) begin failures++; $display("FAIL b2b_commit got mode=%0d busy=%0b exp %0d/%0b", mode, busy, mMode, expBusy()); end
`ifndef BLANK_ON_SWITCH_EN
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL b2b_direct got=%0d exp=0", mode); end
`endif
        frameDone = 1'b1; tick(); frameDone = 1'b0; tick();
        send = 1'b1; frameDone = 1'b1; tick();
        send = 1'b0; frameDone = 1'b0;
        checks++; if (go !== expGo()) begin failures++; $display("FAIL b2b_send_go got=%0b exp=%0b", go, expGo()); end
        checks++; if (go !== 1'b1) begin failures++; $display("FAIL b2b_send_kept got=%0b exp=1", go); end
        frameDone = 1'b1; tick(); frameDone = 1'b0;
        checks++; if (go !== 1'b0) begin failures++; $display("FAIL b2b_send_clear got=%0b exp=0", go); end
    endtask

    task automatic test_reset_pending();
        modeSet = 2'd3; changeMode = 1'b1; tick();
        changeMode = 1'b0; tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rp_pending got=%0b exp=1", busy); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (mode !== 2'd0 || busy !== 1'b0 || go !== 1'b0) begin failures++; $display("FAIL rp_reset got mode=%0d busy=%0b go=%0b exp 0/0/0", mode, busy, go); end
        frameDone = 1'b1; tick(); frameDone = 1'b0; tick();
        checks++; if (mode !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL rp_no_commit got mode=%0d busy=%0b exp 0/0", mode, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 79) != 0);
            changeMode = ($urandom_range(0, 3) == 0);
            modeSet    = 2'($urandom);
            send       = ($urandom_range(0, 2) == 0);
            frameDone  = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 15) == 0) begin
                Green = 4'($urandom); Red = 4'($urandom); Blue = 4'($urandom);
                for (int k = 0; k < 9; k++) extData[k*32 +: 32] = $urandom;
            end
            tick();
            checks++; if (mode !== 2'(mMode)) begin failures++; $display("FAIL rnd_mode[%0d] got=%0d exp=%0d", i, mode, mMode); end
            checks++; if (busy !== expBusy()) begin failures++; $display("FAIL rnd_busy[%0d] got=%0b exp=%0b", i, busy, expBusy()); end
            checks++; if (go !== expGo()) begin failures++; $display("FAIL rnd_go[%0d] got=%0b exp=%0b", i, go, expGo()); end
            checks++; if (regVal !== expReg) begin failures++; $display("FAIL rnd_regVal[%0d] got=%0h exp=%0h", i, regVal, expReg); end
        end
        reset = 1'b1; changeMode = 1'b0; send = 1'b0; frameDone = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; changeMode = 1'b0; modeSet = '0; send = 1'b0;
        Green = '0; Red = '0; Blue = '0; extData = '0; frameDone = 1'b0;
        changeMode3 = 1'b0; modeSet3 = '0; frameDone3 = 1'b0; extData3 = '0;
        mPrevCh = 0; mPrevSend = 0; mPendFlag = 0; mBlank = 0; mSendReq = 0;
        mMode = 0; mPend = 0; expReg = '0;
        test_reset();
        test_mode0_frame();
        test_send();
        test_mode_switch();
        test_overwrite();
        test_invalid_mode3();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
